// File: rtl/reg_access_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the shared test register.
// The slave modport is the arbiter's view; master is the client/register side.
interface reg_access_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic [1:0]            req;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] req_data0;
  logic [DATA_WIDTH-1:0] req_data1;
  logic [1:0]            ack;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  busy;
  logic                  reg_en;
  logic                  reg_state;
  logic [DATA_WIDTH-1:0] reg_rd_data;
  logic [DATA_WIDTH-1:0] reg_wr_data;

  modport slave (
    input  req, op, req_data0, req_data1, reg_wr_data,
    output ack, rsp_data, busy, reg_en, reg_state, reg_rd_data
  );

  modport master (
    output req, op, req_data0, req_data1, reg_wr_data,
    input  ack, rsp_data, busy, reg_en, reg_state, reg_rd_data
  );
endinterface

// File: rtl/reg_access_arbiter.sv
// Two-requester arbiter sequencing a single-word test register (IDLE->EN->SETTLE->ACK).
// Define REG_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module reg_access_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int EN_CYCLES  = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  reg_access_arbiter_if.slave  bus
);

  if (EN_CYCLES < 1 || EN_CYCLES > 15) begin : g_bad_en_cycles
    $error("reg_access_arbiter: EN_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EN,
    S_SETTLE,
    S_ACK
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  winner_q, winner_d;
  logic                  pick;
  logic [1:0]            ack_d;
  logic [DATA_WIDTH-1:0] rsp_d;
  logic                  busy_d;
  logic                  en_d;
  logic                  dir_d;
  logic [DATA_WIDTH-1:0] rd_d;

`ifdef REG_ARB_FIXED_PRIO_EN
  assign pick = ~bus.req[0];
`else
  logic last_q;

  // A tie goes to whoever was not granted last; a lone requester always wins.
  assign pick = (&bus.req) ? ~last_q : bus.req[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (state_q == S_IDLE && |bus.req) begin
      last_q <= pick;
    end
  end
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    ack_d    = '0;
    rsp_d    = bus.rsp_data;
    busy_d   = bus.busy;
    en_d     = bus.reg_en;
    dir_d    = bus.reg_state;
    rd_d     = bus.reg_rd_data;

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          winner_d = pick;
          busy_d   = 1'b1;
          en_d     = 1'b1;
          dir_d    = bus.op[pick];
          rd_d     = pick ? bus.req_data1 : bus.req_data0;
          cnt_d    = 4'(EN_CYCLES - 1);
          state_d  = S_EN;
        end
      end
      S_EN: begin
        if (cnt_q == 4'd0) begin
          en_d    = 1'b0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SETTLE: begin
        // Fetch returns the register's output; capture echoes the data just written.
        rsp_d           = bus.reg_state ? bus.reg_wr_data : bus.reg_rd_data;
        ack_d[winner_q] = 1'b1;
        state_d         = S_ACK;
      end
      S_ACK: begin
        busy_d  = 1'b0;
        dir_d   = 1'b0;
        rd_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      winner_q        <= 1'b0;
      bus.ack         <= '0;
      bus.rsp_data    <= '0;
      bus.busy        <= 1'b0;
      bus.reg_en      <= 1'b0;
      bus.reg_state   <= 1'b0;
      bus.reg_rd_data <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      winner_q        <= winner_d;
      bus.ack         <= ack_d;
      bus.rsp_data    <= rsp_d;
      bus.busy        <= busy_d;
      bus.reg_en      <= en_d;
      bus.reg_state   <= dir_d;
      bus.reg_rd_data <= rd_d;
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: dut_a uses EN_CYCLES=1, dut_b uses EN_CYCLES=3.
// Expected ack patterns follow REG_ARB_FIXED_PRIO_EN when it is defined.
module tb_reg_access_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reg_access_arbiter_if #(.DATA_WIDTH(16)) a ();
  reg_access_arbiter_if #(.DATA_WIDTH(16)) b ();

  reg_access_arbiter #(.DATA_WIDTH(16), .EN_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a.slave)
  );
  reg_access_arbiter #(.DATA_WIDTH(16), .EN_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a.req = '0; a.op = '0; a.req_data0 = '0; a.req_data1 = '0; a.reg_wr_data = '0;
    b.req = '0; b.op = '0; b.req_data0 = '0; b.req_data1 = '0; b.reg_wr_data = '0;
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (a.ack !== 2'b00) begin errors++; $display("FAIL rst_ack: got %h want 0", a.ack); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", a.busy); end
    checks++; if (a.reg_en !== 1'b0) begin errors++; $display("FAIL rst_reg_en: got %b want 0", a.reg_en); end
    checks++; if (a.reg_state !== 1'b0) begin errors++; $display("FAIL rst_reg_state: got %b want 0", a.reg_state); end
    checks++; if (a.reg_rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data: got %h want 0", a.reg_rd_data); end
    checks++; if (a.rsp_data !== 16'h0) begin errors++; $display("FAIL rst_rsp: got %h want 0", a.rsp_data); end
    checks++;
    if ({b.ack, b.busy, b.reg_en, b.reg_state, b.reg_rd_data, b.rsp_data} !== '0) begin
      errors++; $display("FAIL rst_dut_b: got ack=%h busy=%b en=%b", b.ack, b.busy, b.reg_en);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    a.req = 2'b01; a.op = 2'b00; a.req_data0 = 16'h1234;
    tick();
    checks++; if (a.reg_en !== 1'b1) begin errors++; $display("FAIL cap_en: got %b want 1", a.reg_en); end
    checks++; if (a.reg_state !== 1'b0) begin errors++; $display("FAIL cap_state: got %b want 0", a.reg_state); end
    checks++; if (a.reg_rd_data !== 16'h1234) begin errors++; $display("FAIL cap_rd_data: got %h want 1234", a.reg_rd_data); end
    checks++; if (a.busy !== 1'b1) begin errors++; $display("FAIL cap_busy: got %b want 1", a.busy); end
    tick();
    checks++; if (a.reg_en !== 1'b0) begin errors++; $display("FAIL cap_settle_en: got %b want 0", a.reg_en); end
    checks++; if (a.ack !== 2'b00) begin errors++; $display("FAIL cap_settle_ack: got %h want 0", a.ack); end
    checks++; if (a.reg_rd_data !== 16'h1234) begin errors++; $display("FAIL cap_settle_hold: got %h want 1234", a.reg_rd_data); end
    tick();
    checks++; if (a.ack !== 2'b01) begin errors++; $display("FAIL cap_ack: got %h want 01", a.ack); end
    checks++; if (a.rsp_data !== 16'h1234) begin errors++; $display("FAIL cap_rsp: got %h want 1234", a.rsp_data); end
    a.req = 2'b00;
    tick();
    checks++; if (a.ack !== 2'b00) begin errors++; $display("FAIL cap_ack_end: got %h want 0", a.ack); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL cap_busy_end: got %b want 0", a.busy); end
    checks++; if (a.reg_rd_data !== 16'h0) begin errors++; $display("FAIL cap_rd_clr: got %h want 0", a.reg_rd_data); end
    tick();
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL cap_no_regrant: got %b want 0", a.busy); end
  endtask

  task automatic test_fetch();
    a.req = 2'b10; a.op = 2'b10; a.req_data1 = 16'h5A5A; a.reg_wr_data = 16'hBEEF;
    tick();
    checks++; if (a.reg_state !== 1'b1) begin errors++; $display("FAIL fet_state: got %b want 1", a.reg_state); end
    checks++; if (a.reg_en !== 1'b1) begin errors++; $display("FAIL fet_en: got %b want 1", a.reg_en); end
    tick();
    checks++; if (a.reg_state !== 1'b1) begin errors++; $display("FAIL fet_settle_state: got %b want 1", a.reg_state); end
    tick();
    checks++; if (a.ack !== 2'b10) begin errors++; $display("FAIL fet_ack: got %h want 10", a.ack); end
    checks++; if (a.rsp_data !== 16'hBEEF) begin errors++; $display("FAIL fet_rsp: got %h want beef", a.rsp_data); end
    a.req = 2'b00; a.op = 2'b00;
    tick();
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL fet_busy_end: got %b want 0", a.busy); end
    checks++; if (a.reg_state !== 1'b0) begin errors++; $display("FAIL fet_state_clr: got %b want 0", a.reg_state); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_ack;
    logic [15:0] exp_rsp;
    a.req = 2'b11; a.op = 2'b00; a.req_data0 = 16'hA0A0; a.req_data1 = 16'hB1B1;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_ack = 2'b00;
      if (k % 4 == 2) begin
`ifdef REG_ARB_FIXED_PRIO_EN
        exp_ack = 2'b01;
`else
        exp_ack = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
`endif
      end
      checks++;
      if (a.ack !== exp_ack) begin errors++; $display("FAIL b2b_ack[%0d]: got %h want %h", k, a.ack, exp_ack); end
      if (exp_ack != 2'b00) begin
        exp_rsp = (exp_ack == 2'b01) ? 16'hA0A0 : 16'hB1B1;
        checks++;
        if (a.rsp_data !== exp_rsp) begin errors++; $display("FAIL b2b_rsp[%0d]: got %h want %h", k, a.rsp_data, exp_rsp); end
      end
      if (k == 14) a.req = 2'b00;
    end
    tick();
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", a.busy); end
  endtask

  task automatic test_en_cycles3();
    logic       exp_en;
    logic [1:0] exp_ack;
    b.req = 2'b01; b.op = 2'b00; b.req_data0 = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_en  = (k < 3);
      exp_ack = (k == 4) ? 2'b01 : 2'b00;
      checks++;
      if (b.reg_en !== exp_en) begin errors++; $display("FAIL en3_en[%0d]: got %b want %b", k, b.reg_en, exp_en); end
      checks++;
      if (b.ack !== exp_ack) begin errors++; $display("FAIL en3_ack[%0d]: got %h want %h", k, b.ack, exp_ack); end
      if (k == 3) begin
        checks++;
        if (b.reg_rd_data !== 16'hFFFF) begin errors++; $display("FAIL en3_settle_hold: got %h want ffff", b.reg_rd_data); end
      end
      if (k == 4) begin
        checks++;
        if (b.rsp_data !== 16'hFFFF) begin errors++; $display("FAIL en3_rsp: got %h want ffff", b.rsp_data); end
        b.req = 2'b00;
      end
    end
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL en3_busy_end: got %b want 0", b.busy); end
  endtask

  task automatic test_reset_mid();
    a.req = 2'b01; a.op = 2'b00; a.req_data0 = 16'h5555;
    tick();
    checks++; if (a.reg_en !== 1'b1) begin errors++; $display("FAIL rmid_pre_en: got %b want 1", a.reg_en); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (a.reg_en !== 1'b0) begin errors++; $display("FAIL rmid_en: got %b want 0", a.reg_en); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", a.busy); end
    checks++; if (a.ack !== 2'b00) begin errors++; $display("FAIL rmid_ack: got %h want 0", a.ack); end
    a.req = 2'b00;
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (a.ack !== 2'b00) begin errors++; $display("FAIL rmid_no_ack[%0d]: got %h want 0", k, a.ack); end
    end
    a.req = 2'b11; a.req_data0 = 16'h1111; a.req_data1 = 16'h2222;
    tick();
    checks++; if (a.reg_rd_data !== 16'h1111) begin errors++; $display("FAIL rmid_tie_data: got %h want 1111", a.reg_rd_data); end
    a.req = 2'b01;
    tick(); tick();
    checks++; if (a.ack !== 2'b01) begin errors++; $display("FAIL rmid_tie_ack: got %h want 01", a.ack); end
    checks++; if (a.rsp_data !== 16'h1111) begin errors++; $display("FAIL rmid_tie_rsp: got %h want 1111", a.rsp_data); end
    a.req = 2'b00;
    tick();
  endtask

  task automatic test_req_drop();
    int acks;
    acks = 0;
    a.req = 2'b01; a.op = 2'b00; a.req_data0 = 16'h7777;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 1) a.req = 2'b00;
      if (a.ack != 2'b00) acks++;
      if (k == 2) begin
        checks++;
        if (a.ack !== 2'b01) begin errors++; $display("FAIL drop_ack: got %h want 01", a.ack); end
      end
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL drop_ack_count: got %0d want 1", acks); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b want 0", a.busy); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_fetch();
    test_back_to_back();
    test_en_cycles3();
    test_reset_mid();
    test_req_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
